// File: rtl/modmul_sched.sv
// modmul_sched
// Round-robin scheduler that shares one 256-bit modular multiplier among
// N_REQ requesters. One request is granted at a time. The operands are latched
// onto mm_X/mm_Y. The multiplier is then cleared, released, launched and
// waited on. Its done flag is sticky until mm_rst, so every job must start
// with a clear. The result goes out on a single-entry response port, tagged
// with the index of the requester that owns it.
//
// Ports:
//   clock, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid/x/y         per-requester request bit and packed 256-bit operands
//   req_ready             one-hot, one-cycle grant pulse
//   resp_valid/ready      response handshake
//   resp_q/id/err         result, owning requester, timeout flag
//   busy                  high whenever the scheduler is not idle
//   mm_X/mm_Y/mm_start/mm_rst  multiplier drive (mm_rst is active-high)
//   mm_Q/mm_done          multiplier result and sticky done
//
// Optional feature: define MODMUL_SCHED_TIMEOUT_EN to bound the wait for
// mm_done to TIMEOUT_CYC cycles. On expiry the block answers with resp_err=1.
// Without the macro the wait is unbounded and resp_err is tied to 0.
//
// Every output is registered. Each output flop is computed from the next
// state, so the multiplier controls line up with the state they belong to.
// A grant is decided in the IDLE cycle. req_ready is visible during CLEAR,
// together with mm_rst. mm_start is high in LAUNCH, three cycles after the
// IDLE grant cycle.

module modmul_sched #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*256-1:0] req_x,
  input  logic [N_REQ*256-1:0] req_y,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [255:0]         resp_q,
  output logic [2:0]           resp_id,
  output logic                 resp_err,
  output logic                 busy,
  output logic [255:0]         mm_X,
  output logic [255:0]         mm_Y,
  output logic                 mm_start,
  output logic                 mm_rst,
  input  logic [255:0]         mm_Q,
  input  logic                 mm_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GAP,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         last_grant_q, last_grant_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic [255:0]       resp_q_q, resp_q_d;
  logic [2:0]         resp_id_q, resp_id_d;
  logic               busy_q, busy_d;
  logic [255:0]       mm_x_q, mm_x_d;
  logic [255:0]       mm_y_q, mm_y_d;
  logic               mm_start_q, mm_start_d;
  logic               mm_rst_q, mm_rst_d;

`ifdef MODMUL_SCHED_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               resp_err_q, resp_err_d;
`else
  logic               unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
`endif

  // Round-robin pick. Search upward from last_grant+1, wrapping at N_REQ.
  // The first set request bit wins. Shifts are used instead of variable
  // selects so that the index stays a plain integer.
  logic               grant_found;
  logic [2:0]         grant_idx;
  logic [255:0]       grant_x, grant_y;

  always_comb begin
    int               cand;
    logic [N_REQ-1:0] vshift;
    logic [N_REQ*256-1:0] xs;
    logic [N_REQ*256-1:0] ys;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_x     = '0;
    grant_y     = '0;
    cand        = 0;
    vshift      = '0;
    xs          = '0;
    ys          = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last_grant_q) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      vshift = req_valid >> cand;
      if (!grant_found && vshift[0]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(cand);
        xs          = req_x >> (cand * 256);
        ys          = req_y >> (cand * 256);
        grant_x     = xs[255:0];
        grant_y     = ys[255:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_ready_d  = '0;
    resp_q_d     = resp_q_q;
    resp_id_d    = resp_id_q;
    mm_x_d       = mm_x_q;
    mm_y_d       = mm_y_q;
`ifdef MODMUL_SCHED_TIMEOUT_EN
    cnt_d        = cnt_q;
    resp_err_d   = resp_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready_d  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx;
          mm_x_d       = grant_x;
          mm_y_d       = grant_y;
          resp_id_d    = grant_idx;
          last_grant_d = grant_idx;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR:  state_d = S_GAP;
      S_GAP:    state_d = S_LAUNCH;
      S_LAUNCH: begin
`ifdef MODMUL_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mm_done) begin
          resp_q_d   = mm_Q;
`ifdef MODMUL_SCHED_TIMEOUT_EN
          resp_err_d = 1'b0;
`endif
          state_d    = S_RESP;
`ifdef MODMUL_SCHED_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          // The multiplier is left hung here. The next job's CLEAR recovers it.
          resp_q_d   = '0;
          resp_err_d = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d      = cnt_q + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mm_rst_d     = (state_d == S_CLEAR);
    mm_start_d   = (state_d == S_LAUNCH);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 3'(N_REQ - 1);
      req_ready_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_q_q     <= '0;
      resp_id_q    <= '0;
      busy_q       <= 1'b0;
      mm_x_q       <= '0;
      mm_y_q       <= '0;
      mm_start_q   <= 1'b0;
      mm_rst_q     <= 1'b1;
`ifdef MODMUL_SCHED_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q_q     <= resp_q_d;
      resp_id_q    <= resp_id_d;
      busy_q       <= busy_d;
      mm_x_q       <= mm_x_d;
      mm_y_q       <= mm_y_d;
      mm_start_q   <= mm_start_d;
      mm_rst_q     <= mm_rst_d;
`ifdef MODMUL_SCHED_TIMEOUT_EN
      cnt_q        <= cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_q     = resp_q_q;
  assign resp_id    = resp_id_q;
  assign busy       = busy_q;
  assign mm_X       = mm_x_q;
  assign mm_Y       = mm_y_q;
  assign mm_start   = mm_start_q;
  assign mm_rst     = mm_rst_q;
`ifdef MODMUL_SCHED_TIMEOUT_EN
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_modmul_sched.sv
// Testbench for modmul_sched. The multiplier model keeps done sticky until
// mm_rst and returns X*Y mod 2^256. Expected grants and results come from a
// round-robin reference computed on the request masks.

module tb_modmul_sched;

  localparam int N  = 4;
  localparam int TO = 50;

  logic               clock = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N*256-1:0]   req_x = '0;
  logic [N*256-1:0]   req_y = '0;
  logic [N-1:0]       req_ready;
  logic               resp_valid;
  logic               resp_ready = 1'b0;
  logic [255:0]       resp_q;
  logic [2:0]         resp_id;
  logic               resp_err;
  logic               busy;
  logic [255:0]       mm_X, mm_Y;
  logic               mm_start, mm_rst;
  logic [255:0]       mm_Q;
  logic               mm_done;

  int vectors     = 0;
  int miscompares = 0;
  int exp_last    = N - 1;

  // Multiplier model: sticky done, cleared only by mm_rst.
  bit           model_never = 1'b0;
  int           model_lat   = 40;
  logic         model_done  = 1'b0;
  logic         model_pend  = 1'b0;
  int           model_cnt   = 0;
  logic [255:0] model_q     = '0;

  assign mm_Q    = model_q;
  assign mm_done = model_done;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mm_rst) begin
      model_done <= 1'b0;
      model_pend <= 1'b0;
      model_cnt  <= 0;
      model_q    <= '0;
    end else if (mm_start) begin
      model_pend <= 1'b1;
      model_cnt  <= model_lat;
    end else if (model_pend && !model_never) begin
      if (model_cnt <= 1) begin
        model_done <= 1'b1;
        model_q    <= mm_X * mm_Y;
        model_pend <= 1'b0;
      end else begin
        model_cnt <= model_cnt - 1;
      end
    end
  end

  modmul_sched #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_q(resp_q),
    .resp_id(resp_id), .resp_err(resp_err), .busy(busy),
    .mm_X(mm_X), .mm_Y(mm_Y), .mm_start(mm_start), .mm_rst(mm_rst),
    .mm_Q(mm_Q), .mm_done(mm_done)
  );

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] mulq(logic [255:0] a, logic [255:0] b);
    return a * b;
  endfunction

  // Reference arbitration: next requesting index after the previous winner.
  function automatic int rr_expect(int last, logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int r, input logic [255:0] x, input logic [255:0] y);
    req_x[r*256 +: 256] = x;
    req_y[r*256 +: 256] = y;
    req_valid[r] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    req_valid = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    exp_last = N - 1;
  endtask

  task automatic wait_grant(output int g, output bit ok);
    ok = 1'b0;
    g = -1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock);
      if (req_ready !== '0) begin
        ok = 1'b1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      end
    end
  endtask

  task automatic wait_resp(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge clock);
      if (resp_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic accept_resp();
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    vectors++; if ({req_ready, resp_valid, busy, mm_start} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {req_ready, resp_valid, busy, mm_start}); end
    vectors++; if (resp_q !== '0 || resp_id !== 3'd0 || resp_err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_resp: got q=%0h id=%0d err=%b expected 0", resp_q, resp_id, resp_err); end
    vectors++; if (mm_X !== '0 || mm_Y !== '0) begin
      miscompares++; $display("[TB] FAIL reset_operands: got X=%0h Y=%0h expected 0", mm_X, mm_Y); end
    vectors++; if (mm_rst !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_mm_rst: got %b expected 1", mm_rst); end
    rst_n = 1'b1;
    @(negedge clock);
    vectors++; if (mm_rst !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL release_mm_rst: got rst=%b busy=%b expected 0 0", mm_rst, busy); end
  endtask

  task automatic test_single();
    int gc = -1, sc = -1, dc = -1, rc = -1, rst_at = -1, rst_hi = 0, start_hi = 0;
    logic [N-1:0] got_ready = '0;
    model_lat = 40;
    set_req(0, 256'd3, 256'd5);
    for (int c = 1; c <= 300 && rc < 0; c++) begin
      @(negedge clock);
      if (req_ready !== '0 && gc < 0) begin gc = c; got_ready = req_ready; req_valid[0] = 1'b0; end
      if (mm_rst === 1'b1) begin rst_hi++; rst_at = c; end
      if (mm_start === 1'b1) begin start_hi++; sc = c; end
      if (mm_done === 1'b1 && dc < 0) dc = c;
      if (resp_valid === 1'b1) rc = c;
    end
    vectors++; if (got_ready !== 4'b0001) begin
      miscompares++; $display("[TB] FAIL single_ready: got %b expected 0001", got_ready); end
    vectors++; if (rst_hi != 1 || rst_at != gc) begin
      miscompares++; $display("[TB] FAIL single_mm_rst: got %0d cycles at %0d expected 1 at %0d", rst_hi, rst_at, gc); end
    vectors++; if (start_hi != 1 || sc != gc + 2) begin
      miscompares++; $display("[TB] FAIL single_mm_start: got %0d cycles at %0d expected 1 at %0d", start_hi, sc, gc + 2); end
    vectors++; if (dc < 0 || rc != dc + 1) begin
      miscompares++; $display("[TB] FAIL single_resp_latency: got resp at %0d done at %0d expected done+1", rc, dc); end
    vectors++; if (resp_q !== 256'h0F || resp_id !== 3'd0 || resp_err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_resp: got q=%0h id=%0d err=%b expected f 0 0", resp_q, resp_id, resp_err); end
    accept_resp();
    vectors++; if (resp_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_accept: got resp_valid=%b expected 0", resp_valid); end
    exp_last = 0;
  endtask

  task automatic test_fairness();
    logic [N-1:0] mask = 4'b1011;
    logic [255:0] ex, ey;
    int g, e;
    bit ok;
    do_reset();
    for (int r = 0; r < N; r++) if (mask[r]) set_req(r, rand256(), rand256());
    for (int j = 0; j < 6; j++) begin
      model_lat = $urandom_range(1, 20);
      e = rr_expect(exp_last, mask);
      wait_grant(g, ok);
      vectors++; if (!ok || req_ready !== (4'b0001 << e)) begin
        miscompares++; $display("[TB] FAIL fair_grant%0d: got %b expected %b", j, req_ready, 4'b0001 << e); end
      ex = req_x[e*256 +: 256];
      ey = req_y[e*256 +: 256];
      set_req(e, rand256(), rand256());
      exp_last = e;
      wait_resp(200, ok);
      vectors++; if (!ok || resp_id !== 3'(e) || resp_q !== mulq(ex, ey)) begin
        miscompares++; $display("[TB] FAIL fair_resp%0d: got id=%0d q=%0h expected id=%0d q=%0h", j, resp_id, resp_q, e, mulq(ex, ey)); end
      accept_resp();
    end
    req_valid = '0;
  endtask

  task automatic test_sticky();
    logic [255:0] ex, ey;
    int g;
    bit ok;
    set_req(2, rand256(), rand256());
    for (int j = 0; j < 2; j++) begin
      model_lat = $urandom_range(5, 20);
      wait_grant(g, ok);
      ex = req_x[2*256 +: 256];
      ey = req_y[2*256 +: 256];
      if (j == 0) set_req(2, rand256(), rand256()); else req_valid = '0;
      vectors++; if (!ok || g != 2) begin
        miscompares++; $display("[TB] FAIL sticky_grant%0d: got %0d expected 2", j, g); end
      wait_resp(200, ok);
      vectors++; if (!ok || resp_q !== mulq(ex, ey) || resp_id !== 3'd2) begin
        miscompares++; $display("[TB] FAIL sticky_resp%0d: got id=%0d q=%0h expected id=2 q=%0h", j, resp_id, resp_q, mulq(ex, ey)); end
      accept_resp();
    end
    exp_last = 2;
  endtask

  task automatic test_backpressure();
    int r = $urandom_range(0, N - 1);
    int r2, g, e, stable_bad = 0, grant_bad = 0;
    logic [255:0] capq;
    logic [2:0] capid;
    bit ok;
    model_lat = 10;
    set_req(r, rand256(), rand256());
    wait_grant(g, ok);
    req_valid = '0;
    exp_last = r;
    vectors++; if (!ok || g != r) begin
      miscompares++; $display("[TB] FAIL bp_grant: got %0d expected %0d", g, r); end
    wait_resp(200, ok);
    capq = resp_q;
    capid = resp_id;
    r2 = $urandom_range(0, N - 1);
    set_req(r2, rand256(), rand256());
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_q !== capq || resp_id !== capid || busy !== 1'b1) stable_bad++;
      if (req_ready !== '0) grant_bad++;
    end
    vectors++; if (!ok || stable_bad != 0) begin
      miscompares++; $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", stable_bad); end
    vectors++; if (grant_bad != 0) begin
      miscompares++; $display("[TB] FAIL bp_no_grant: got %0d grant cycles expected 0", grant_bad); end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    vectors++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_accept_idle: got valid=%b busy=%b expected 0 0", resp_valid, busy); end
    e = rr_expect(exp_last, req_valid);
    @(negedge clock);
    vectors++; if (req_ready !== (4'b0001 << e)) begin
      miscompares++; $display("[TB] FAIL bp_next_grant: got %b expected %b", req_ready, 4'b0001 << e); end
    req_valid = '0;
    exp_last = e;
    wait_resp(200, ok);
    accept_resp();
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [255:0] ex, ey;
    int g, e;
    bit ok;
    for (int j = 0; j < 8; j++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int r = 0; r < N; r++) if (mask[r]) set_req(r, rand256(), rand256());
      model_lat = $urandom_range(1, 30);
      e = rr_expect(exp_last, mask);
      wait_grant(g, ok);
      ex = req_x[e*256 +: 256];
      ey = req_y[e*256 +: 256];
      req_valid = '0;
      exp_last = e;
      vectors++; if (!ok || g != e) begin
        miscompares++; $display("[TB] FAIL rand_grant%0d: got %0d expected %0d", j, g, e); end
      wait_resp(200, ok);
      repeat ($urandom_range(0, 5)) @(negedge clock);
      vectors++; if (!ok || resp_id !== 3'(e) || resp_q !== mulq(ex, ey) || resp_err !== 1'b0) begin
        miscompares++; $display("[TB] FAIL rand_resp%0d: got id=%0d q=%0h expected id=%0d q=%0h", j, resp_id, resp_q, e, mulq(ex, ey)); end
      accept_resp();
    end
  endtask

`ifdef MODMUL_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int r = $urandom_range(0, N - 1);
    int g, sc = -1, rc = -1;
    logic [255:0] ex, ey;
    bit ok;
    model_never = 1'b1;
    set_req(r, rand256(), rand256());
    wait_grant(g, ok);
    req_valid = '0;
    exp_last = r;
    for (int c = 1; c <= 300 && rc < 0; c++) begin
      @(negedge clock);
      if (mm_start === 1'b1) sc = c;
      if (resp_valid === 1'b1) rc = c;
    end
    vectors++; if (sc < 0 || rc - sc < TO || rc - sc > TO + 2 || resp_err !== 1'b1 || resp_q !== '0) begin
      miscompares++; $display("[TB] FAIL timeout_resp: got delay=%0d err=%b q=%0h expected ~%0d 1 0", rc - sc, resp_err, resp_q, TO); end
    accept_resp();
    model_never = 1'b0;
    model_lat = 8;
    set_req(r, rand256(), rand256());
    ex = req_x[r*256 +: 256];
    ey = req_y[r*256 +: 256];
    wait_grant(g, ok);
    req_valid = '0;
    wait_resp(200, ok);
    vectors++; if (!ok || resp_err !== 1'b0 || resp_q !== mulq(ex, ey)) begin
      miscompares++; $display("[TB] FAIL timeout_recover: got err=%b q=%0h expected 0 %0h", resp_err, resp_q, mulq(ex, ey)); end
    accept_resp();
  endtask
`endif

  task automatic test_reset_in_wait();
    int g;
    bit ok, seen = 1'b0;
    logic [255:0] ex, ey;
    do_reset();
    model_lat = 100;
    set_req(0, rand256(), rand256());
    wait_grant(g, ok);
    req_valid = '0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      if (mm_start === 1'b1) seen = 1'b1;
    end
    repeat (10) @(negedge clock);
    rst_n = 1'b0;
    #1;
    vectors++; if (!seen || busy !== 1'b0 || mm_rst !== 1'b1 || resp_valid !== 1'b0 || mm_start !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rst_wait_async: got busy=%b rst=%b valid=%b expected 0 1 0", busy, mm_rst, resp_valid); end
    repeat (2) @(negedge clock);
    set_req(0, rand256(), rand256());
    set_req(1, rand256(), rand256());
    ex = req_x[255:0];
    ey = req_y[255:0];
    rst_n = 1'b1;
    exp_last = N - 1;
    wait_grant(g, ok);
    req_valid = '0;
    vectors++; if (!ok || g != rr_expect(exp_last, 4'b0011)) begin
      miscompares++; $display("[TB] FAIL rst_wait_first_grant: got %0d expected 0", g); end
    model_lat = 5;
    wait_resp(300, ok);
    vectors++; if (!ok || resp_id !== 3'd0 || resp_q !== mulq(ex, ey)) begin
      miscompares++; $display("[TB] FAIL rst_wait_resp: got id=%0d q=%0h expected 0 %0h", resp_id, resp_q, mulq(ex, ey)); end
    accept_resp();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_sticky();
    test_backpressure();
    test_random();
`ifdef MODMUL_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modmul_sched.md
# modmul_sched

Round-robin scheduler that shares one 256-bit modular multiplier (X·Y → Q) among `N_REQ` requesters. It grants one request at a time and latches the operands. It then sequences the multiplier through clear, launch and wait phases, because the multiplier's `done` is sticky until its reset. Each result is returned on a single-entry response port, tagged with the requester index. The block sits between the request clients and the multiplier top level and is the only driver of the multiplier's `start`, `rst`, `X` and `Y`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, 1023: maximum cycles to wait for `mm_done`. Used only when `MODMUL_SCHED_TIMEOUT_EN` is defined.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  one request-pending bit per requester.
- `req_x`  in  N_REQ*256  packed X operands; requester i uses bits [i*256 +: 256].
- `req_y`  in  N_REQ*256  packed Y operands, same packing as `req_x`.
- `req_ready`  out  N_REQ  one-hot, one-cycle grant/accept pulse.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_q`  out  256  result Q.
- `resp_id`  out  3  index of the requester that owns the result.
- `resp_err`  out  1  result is invalid because of a timeout.
- `busy`  out  1  high in every state except IDLE.
- `mm_X`, `mm_Y`  out  256  multiplier operands, held stable for the whole job.
- `mm_start`  out  1  multiplier start.
- `mm_rst`  out  1  multiplier reset, active-high.
- `mm_Q`  in  256  multiplier result.
- `mm_done`  in  1  multiplier done, sticky until `mm_rst`.

## Operation
- States: IDLE, CLEAR, GAP, LAUNCH, WAIT, RESP.
- IDLE:
  - If any `req_valid` bit is set, grant the first set bit found searching upward (mod N_REQ) from `last_grant+1`.
  - Pulse `req_ready[g]`, latch `req_x[g]`/`req_y[g]` into `mm_X`/`mm_Y`, record `resp_id` = g and set `last_grant` = g.
  - Go to CLEAR.
- CLEAR: `mm_rst`=1 and `mm_start`=0. This clears the sticky `mm_done`. Go to GAP.
- GAP: `mm_rst`=0 and `mm_start`=0, so the multiplier sees `done`=0 before it sees start. Go to LAUNCH.
- LAUNCH: `mm_start`=1 for exactly this one cycle. Clear the wait counter. Go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - On `mm_done`=1: `resp_q` ← `mm_Q`, `resp_err` ← 0, go to RESP.
- RESP:
  - `resp_valid`=1. `resp_q`, `resp_id` and `resp_err` stay stable until `resp_ready`=1.
  - On the accept cycle go to IDLE with `resp_valid`=0.
  - No new grant is made while in RESP.
- Requester contract: hold `req_valid` and the operands until `req_ready` is seen. `req_valid` may drop without penalty before a grant.
- `mm_X`/`mm_Y` change only in the IDLE grant cycle.
- Simultaneous requests: strict round-robin, so no requester waits more than N_REQ−1 jobs.
- `req_valid` bits at indices ≥ N_REQ do not exist. Bits of `resp_id` above $clog2(N_REQ) are 0.

## Timing
- Reset values while `rst_n`=0:
  - State IDLE; `req_ready`=0, `resp_valid`=0, `resp_q`=0, `resp_id`=0, `resp_err`=0, `busy`=0.
  - `mm_X`=0, `mm_Y`=0, `mm_start`=0, `mm_rst`=1, `last_grant`=N_REQ−1, so the first grant goes to requester 0.
- `mm_rst` drops in the first clock after `rst_n` deasserts.
- Latency:
  - Grant cycle → `mm_start` pulse: 3 cycles (CLEAR, GAP, LAUNCH).
  - `mm_done` sampled high → `resp_valid` high: 1 cycle.
- Back-to-back jobs: resp accept → earliest next grant is 1 cycle (IDLE).
- Reset mid-operation: the asynchronous `rst_n` immediately returns every output to its reset value. Any in-flight job is dropped with no response, and the multiplier is reset through `mm_rst`=1.
- All outputs are registered.

## Configuration
- `MODMUL_SCHED_TIMEOUT_EN` defined:
  - If the WAIT counter reaches `TIMEOUT_CYC` without `mm_done`, go to RESP with `resp_q`=0 and `resp_err`=1.
  - The multiplier is recovered by the next job's CLEAR.
- Not defined:
  - WAIT has no limit, the counter logic is absent, and `resp_err` is tied to 0.

## Test plan
- Single request: req 0 with X=3, Y=5 and a multiplier model returning Q=0x0F after 40 cycles → `req_ready[0]` pulse; `mm_rst` high exactly 1 cycle; `mm_start` high exactly 1 cycle, 3 cycles after grant; `resp_valid` with `resp_q`=0x0F, `resp_id`=0.
- Round-robin fairness: requesters 0, 1 and 3 hold `req_valid` continuously → grant order 0, 1, 3, 0, 1, 3, with each response id matching its grant.
- Sticky done: two back-to-back jobs from requester 2 with a model whose `done` stays high until `mm_rst` → the second response carries the second job's Q, never the first Q re-sampled.
- Backpressure: `resp_ready` held low for 20 cycles → `resp_valid`, `resp_q` and `resp_id` stable; no grant is issued; the next grant comes 1 cycle after the accept.
- Timeout (macro on, `TIMEOUT_CYC`=50): model never asserts done → `resp_err`=1 and `resp_q`=0 about 50 cycles after `mm_start`; the next job completes normally with `resp_err`=0.
- Reset in WAIT: pull `rst_n` low 10 cycles after `mm_start` → `busy`=0, `mm_rst`=1, `resp_valid`=0 immediately; after release the first grant goes to requester 0.
